cam_fb_writer: RTL

Downstream stage of the camera capture block: watches its registered `x_coord`/`y_coord`/`pixel_data` outputs, detects each newly latched pixel, and writes it into a double-buffered frame-buffer BRAM. It owns the write side of the frame buffer, frame-boundary detection, bank ping-pong for the display reader, single-shot vs continuous capture, and out-of-window drop accounting.

---
 rtl/cam_fb_writer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cam_fb_writer.sv
// rtl/cam_fb_writer.sv - double-buffered frame-buffer writer for the camera capture path
//
// Watches the capture stage's registered x/y/pixel outputs and writes each newly
// latched in-window pixel into one bank of a two-bank frame buffer. A completed
// frame (next start-of-frame seen while capturing) flips the banks so the display
// reader always has a stable, fully written frame in disp_bank.
//
// Ports:
//   pclk, reset_n           pixel clock, asynchronous active-low reset
//   enable, single          capture permit level, single-shot select (sampled at frame end)
//   x_coord, y_coord        column / row counters from the capture stage (x = 0 between pixels of a new row)
//   pixel_data              pixel byte, valid when x_coord changes
//   bram_we/addr/din        frame-buffer write port, addr = {bank, row*WIDTH+col}
//   disp_bank               bank holding the most recently completed frame
//   frame_valid             sticky: a frame has completed since reset
//   frame_done              one-cycle pulse per completed frame
//   busy                    waiting for start-of-frame or capturing
//   drop_count              saturating count of out-of-window pixels seen while capturing
module cam_fb_writer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int PIX_AW = 17
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              single,
    input  logic [9:0]        x_coord,
    input  logic [9:0]        y_coord,
    input  logic [7:0]        pixel_data,
    output logic              bram_we,
    output logic [PIX_AW:0]   bram_addr,
    output logic [7:0]        bram_din,
    output logic              disp_bank,
    output logic              frame_valid,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        drop_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_CAPTURE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [9:0]        r_x_prev;
    logic [9:0]        r_y_prev;
    logic              r_wr_bank;
    logic              r_disp_bank;
    logic              r_frame_valid;
    logic              r_frame_done;
    logic              r_bram_we;
    logic [PIX_AW:0]   r_bram_addr;
    logic [7:0]        r_bram_din;
    logic [7:0]        r_drop_count;

    logic              w_pix_ev;
    logic              w_sof;
    logic              w_in_win;
    logic [9:0]        w_col;
    logic [PIX_AW-1:0] w_lin_addr;
    logic              w_busy;
    logic              w_wr;
    logic              w_drop;
    logic              w_frame_end;

    // A new pixel is any change of x to a non-zero value; x = 0 marks a row start.
    assign w_pix_ev   = (x_coord != r_x_prev) && (x_coord != 10'd0);
    // y_prev resets to all-ones so a clean frame start right after reset is caught,
    // while a reset in the middle of row 0 never sees x return to 0 with y = 0.
    assign w_sof      = (y_coord == 10'd0) && (x_coord == 10'd0) && (r_y_prev != 10'd0);
    assign w_col      = x_coord - 10'd1;
    assign w_in_win   = (32'(w_col) < WIDTH) && (32'(y_coord) < HEIGHT);
    assign w_lin_addr = PIX_AW'(32'(y_coord) * WIDTH + 32'(w_col));

    // State register
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sof) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // The sof that completes a frame also starts the next one.
                if (w_sof) begin
                    w_state_nxt = (single || !enable) ? S_IDLE : S_CAPTURE;
                end else if (!enable) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / action decode
    always_comb begin
        w_busy      = 1'b0;
        w_frame_end = 1'b0;
        w_wr        = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_WAIT_SOF: begin
                w_busy = 1'b1;
            end
            S_CAPTURE: begin
                w_busy      = 1'b1;
                w_frame_end = w_sof;
                // Dropping enable stops writes on the very edge that samples it.
                w_wr        = enable && w_pix_ev && w_in_win;
                w_drop      = enable && w_pix_ev && !w_in_win;
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_x_prev      <= 10'd0;
            r_y_prev      <= 10'h3FF;
            r_wr_bank     <= 1'b0;
            r_disp_bank   <= 1'b1;
            r_frame_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_bram_we     <= 1'b0;
            r_bram_addr   <= '0;
            r_bram_din    <= 8'd0;
            r_drop_count  <= 8'd0;
        end else begin
            r_x_prev     <= x_coord;
            r_y_prev     <= y_coord;
            r_bram_we    <= w_wr;
            r_frame_done <= w_frame_end;
            if (w_wr) begin
                r_bram_addr <= {r_wr_bank, w_lin_addr};
                r_bram_din  <= pixel_data;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            if (w_frame_end) begin
                r_frame_valid <= 1'b1;
                r_disp_bank   <= r_wr_bank;
                r_wr_bank     <= ~r_wr_bank;
            end
        end
    end

    assign bram_we     = r_bram_we;
    assign bram_addr   = r_bram_addr;
    assign bram_din    = r_bram_din;
    assign disp_bank   = r_disp_bank;
    assign frame_valid = r_frame_valid;
    assign frame_done  = r_frame_done;
    assign busy        = w_busy;
    assign drop_count  = r_drop_count;

endmodule
